// File: rtl/regfile_pkg.sv
// Shared constants for the write-back register file: control FSM encodings
// and the write-back source select values.
package regfile_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRAIN = 2'd1;
  localparam state_t ST_CLEAR = 2'd2;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on write-back capture,
// flushed wholesale by the clear sequence; one lookup per read port.
module regfile_scoreboard #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned NREAD = 2,
  parameter int unsigned AW    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [AW-1:0]       set_idx,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_idx,
  input  logic                flush,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD-1:0]    rd_busy
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  // Ordering matters: a newer producer overrides the retiring one, flush overrides both.
  always_comb begin
    busy_next = busy_reg;
    if (clr_en) busy_next[clr_idx] = 1'b0;
    if (set_en) busy_next[set_idx] = 1'b1;
    if (flush)  busy_next = '0;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_lookup
      assign rd_busy[gi] = busy_reg[rd_addr[gi*AW +: AW]];
    end
  endgenerate

endmodule

// File: rtl/regfile_wb_sb.sv
// Integer register file with a one-deep pending write-back stage, read
// bypass, busy scoreboard, bypass-free debug port and a sequenced clear.
module regfile_wb_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned NREGS = 32,
  parameter  int unsigned NREAD = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  output logic [NREAD-1:0]      rs_busy,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_rd,
  input  logic                  wb_sel,
  input  logic [XLEN-1:0]       wb_alu_data,
  input  logic [XLEN-1:0]       wb_mem_data,
  input  logic                  clr_req,
  output logic                  ready,
  input  logic [AW-1:0]         dbg_addr,
  output logic [XLEN-1:0]       dbg_data
);

  state_t          state_reg, state_next;
  logic [AW-1:0]   idx_reg, idx_next;
  logic            flush;
  logic            pend_v_reg;
  logic [AW-1:0]   pend_rd_reg;
  logic [XLEN-1:0] pend_data_reg;
  logic [XLEN-1:0] regs_reg [NREGS];
  logic            wb_accept, iss_accept;
  logic [XLEN-1:0] wb_data;

  assign ready      = (state_reg == ST_IDLE);
  assign wb_accept  = wb_valid && ready && (wb_rd != '0);
  assign iss_accept = iss_valid && ready && (iss_rd != '0);
  assign wb_data    = (wb_sel == WB_SEL_MEM) ? wb_mem_data : wb_alu_data;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    flush      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (clr_req) begin
          if (pend_v_reg) begin
            state_next = ST_DRAIN;
          end else begin
            state_next = ST_CLEAR;
            idx_next   = AW'(1);
            flush      = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        state_next = ST_CLEAR;
        idx_next   = AW'(1);
        flush      = 1'b1;
      end
      ST_CLEAR: begin
        if (idx_reg == AW'(NREGS - 1)) state_next = ST_IDLE;
        else idx_next = idx_reg + AW'(1);
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      pend_v_reg    <= 1'b0;
      pend_rd_reg   <= '0;
      pend_data_reg <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      pend_v_reg <= wb_accept;
      if (wb_accept) begin
        pend_rd_reg   <= wb_rd;
        pend_data_reg <= wb_data;
      end
    end
  end

  // Clearing is written after the commit so a same-edge collision ends at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs_reg[i] <= '0;
    end else begin
      if (pend_v_reg) regs_reg[pend_rd_reg] <= pend_data_reg;
      if (state_reg == ST_CLEAR) regs_reg[idx_reg] <= '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_read
      logic [AW-1:0] addr;
      assign addr = rs_addr[gi*AW +: AW];
      assign rs_data[gi*XLEN +: XLEN] =
        (pend_v_reg && (addr == pend_rd_reg)) ? pend_data_reg : regs_reg[addr];
    end
  endgenerate

  assign dbg_data = regs_reg[dbg_addr];

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD),
    .AW    (AW)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (iss_accept),
    .set_idx (iss_rd),
    .clr_en  (wb_accept),
    .clr_idx (wb_rd),
    .flush   (flush),
    .rd_addr (rs_addr),
    .rd_busy (rs_busy)
  );

endmodule

// File: tb/tb_regfile_wb_sb.sv
// Bench for regfile_wb_sb: vector table for write-back/bypass/scoreboard,
// hand sequences for clear timing and reset during clear.
module tb_regfile_wb_sb;

  parameter int XLEN  = 32;
  parameter int NREGS = 32;
  parameter int NREAD = 2;
  localparam int AW = $clog2(NREGS);

  localparam int K_RS = 0, K_BUSY = 1, K_DBG = 2, K_RDY = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREAD*AW-1:0]   rs_addr;
  logic [NREAD*XLEN-1:0] rs_data;
  logic [NREAD-1:0]      rs_busy;
  logic                  iss_valid;
  logic [AW-1:0]         iss_rd;
  logic                  wb_valid;
  logic [AW-1:0]         wb_rd;
  logic                  wb_sel;
  logic [XLEN-1:0]       wb_alu_data;
  logic [XLEN-1:0]       wb_mem_data;
  logic                  clr_req;
  logic                  ready;
  logic [AW-1:0]         dbg_addr;
  logic [XLEN-1:0]       dbg_data;

  always #100 clk = ~clk;

  regfile_wb_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_sel(wb_sel), .wb_alu_data(wb_alu_data), .wb_mem_data(wb_mem_data),
    .clr_req(clr_req), .ready(ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [63:0]   exp;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic            wbv;
    logic [AW-1:0]   wrd;
    logic            sel;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] mem;
    logic            issv;
    logic [AW-1:0]   ird;
    logic [AW-1:0]   ca;
    logic [XLEN-1:0] ers;
    logic            ebusy;
    logic [XLEN-1:0] edbg;
  } vec_t;
  vec_t vt[13];

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mkv(input logic wbv, input int wrd, input logic sel,
                               input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mem,
                               input logic issv, input int ird, input int ca,
                               input logic [XLEN-1:0] ers, input logic ebusy,
                               input logic [XLEN-1:0] edbg);
    vec_t v;
    v.wbv = wbv; v.wrd = AW'(wrd); v.sel = sel; v.alu = alu; v.mem = mem;
    v.issv = issv; v.ird = AW'(ird); v.ca = AW'(ca);
    v.ers = ers; v.ebusy = ebusy; v.edbg = edbg;
    return v;
  endfunction

  function automatic logic [XLEN-1:0] val(input int r);
    return XLEN'(32'h1234_0000 + r * 32'h0000_0101);
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_RS:    return "rs_data";
      K_BUSY:  return "rs_busy";
      K_DBG:   return "dbg_data";
      default: return "ready";
    endcase
  endfunction

  task automatic compare(input string what, input int addr, input int port,
                         input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s addr=%0d port=%0d got=%h want=%h t=%0t", what, addr, port, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int kind, input int addr, input logic [63:0] exp);
    exp_t e;
    e.kind = kind; e.addr = AW'(addr); e.exp = exp;
    sbq.push_back(e);
  endtask

  // Pops every queued expectation and compares it against the live outputs.
  task automatic drain_sb();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        K_RS, K_BUSY: begin
          for (int p = 0; p < NREAD; p++) begin
            rs_addr = '0;
            rs_addr[p*AW +: AW] = e.addr;
            #1;
            if (e.kind == K_RS) compare(kname(e.kind), int'(e.addr), p, 64'(rs_data[p*XLEN +: XLEN]), e.exp);
            else                compare(kname(e.kind), int'(e.addr), p, 64'(rs_busy[p]), e.exp);
          end
        end
        K_DBG: begin
          dbg_addr = e.addr;
          #1;
          compare(kname(e.kind), int'(e.addr), 0, 64'(dbg_data), e.exp);
        end
        default: begin
          #1;
          compare(kname(e.kind), 0, 0, 64'(ready), e.exp);
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    iss_valid = 1'b0; iss_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_sel = 1'b0;
    wb_alu_data = '0; wb_mem_data = '0;
    clr_req = 1'b0;
  endtask

  task automatic expect_all_zero();
    push_exp(K_RDY, 0, 64'd1);
    for (int r = 0; r < NREGS; r++) begin
      push_exp(K_RS, r, 64'd0);
      push_exp(K_BUSY, r, 64'd0);
      push_exp(K_DBG, r, 64'd0);
    end
    drain_sb();
  endtask

  // Runs the clear sequence from the edge after clr_req; returns cycles with ready low.
  task automatic run_clear(input bit poke, input int stop_at, output int lowc, output bit done);
    lowc = 0;
    done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!ready) begin
        lowc++;
        if (lowc == stop_at) begin
          done = 1'b1;
          break;
        end
        if (poke) begin
          wb_valid = 1'b1; wb_rd = AW'(2); wb_sel = 1'b0; wb_alu_data = '1;
          iss_valid = 1'b1; iss_rd = AW'(2); clr_req = 1'b1;
        end
        tick();
      end else begin
        idle_in();
        done = 1'b1;
        break;
      end
    end
    idle_in();
  endtask

  initial begin
    #(200 * 20000);
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  lowc;
    bit  done;

    rst_n = 1'b0;
    idle_in();
    rs_addr = '0;
    dbg_addr = '0;
    repeat (2) tick();
    expect_all_zero();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    vt[0]  = mkv(1,  5, 0, 'hDEADBEEF, 'h0,  0, 0,  5, 'hDEADBEEF, 0, 'h0);
    vt[1]  = mkv(0,  0, 0, 'h0,        'h0,  0, 0,  5, 'hDEADBEEF, 0, 'hDEADBEEF);
    vt[2]  = mkv(1,  3, 1, 'hAA,       'h11, 0, 0,  3, 'h11,       0, 'h0);
    vt[3]  = mkv(1,  3, 0, 'h22,       'hBB, 0, 0,  3, 'h22,       0, 'h11);
    vt[4]  = mkv(0,  0, 0, 'h0,        'h0,  0, 0,  3, 'h22,       0, 'h22);
    vt[5]  = mkv(0,  0, 0, 'h0,        'h0,  1, 7,  7, 'h0,        1, 'h0);
    vt[6]  = mkv(1,  7, 0, 'h77,       'h0,  1, 7,  7, 'h77,       1, 'h0);
    vt[7]  = mkv(1,  7, 0, 'h78,       'h0,  0, 0,  7, 'h78,       0, 'h77);
    vt[8]  = mkv(1,  0, 0, 'h55,       'h0,  1, 0,  0, 'h0,        0, 'h0);
    vt[9]  = mkv(0,  0, 0, 'h0,        'h0,  0, 0,  7, 'h78,       0, 'h78);
    vt[10] = mkv(0,  0, 0, 'h0,        'h0,  1, 9,  9, 'h0,        1, 'h0);
    vt[11] = mkv(1,  9, 1, 'h66,       'h99, 0, 0,  9, 'h99,       0, 'h0);
    vt[12] = mkv(0,  0, 0, 'h0,        'h0,  0, 0,  5, 'hDEADBEEF, 0, 'hDEADBEEF);

    for (int i = 0; i < 13; i++) begin
      wb_valid = vt[i].wbv; wb_rd = vt[i].wrd; wb_sel = vt[i].sel;
      wb_alu_data = vt[i].alu; wb_mem_data = vt[i].mem;
      iss_valid = vt[i].issv; iss_rd = vt[i].ird;
      tick();
      idle_in();
      push_exp(K_RS, int'(vt[i].ca), 64'(vt[i].ers));
      push_exp(K_BUSY, int'(vt[i].ca), 64'(vt[i].ebusy));
      push_exp(K_DBG, int'(vt[i].ca), 64'(vt[i].edbg));
      push_exp(K_RDY, 0, 64'd1);
      drain_sb();
      $display("vec %0d: wb=%0b rd=%0d sel=%0b iss=%0b ird=%0d check_addr=%0d",
               i, vt[i].wbv, vt[i].wrd, vt[i].sel, vt[i].issv, vt[i].ird, vt[i].ca);
    end

    // Fill every register back-to-back, leaving the last write pending.
    for (int r = 1; r < NREGS; r++) begin
      wb_valid = 1'b1; wb_rd = AW'(r); wb_sel = r[0];
      wb_alu_data = r[0] ? ~val(r) : val(r);
      wb_mem_data = r[0] ? val(r) : ~val(r);
      iss_valid = (r == 10); iss_rd = AW'(4);
      tick();
    end
    idle_in();
    push_exp(K_RS, NREGS - 1, 64'(val(NREGS - 1)));
    push_exp(K_DBG, NREGS - 1, 64'd0);
    push_exp(K_DBG, NREGS - 2, 64'(val(NREGS - 2)));
    push_exp(K_BUSY, 4, 64'd1);
    push_exp(K_RS, 4, 64'(val(4)));
    drain_sb();
    $display("fill: regs 1..%0d written, last pending", NREGS - 1);

    clr_req = 1'b1;
    tick();
    idle_in();
    run_clear(1'b1, 0, lowc, done);
    compare("clear_pend_timeout", 0, 0, 64'(done), 64'd1);
    compare("clear_pend_cycles", 0, 0, 64'(lowc), 64'(NREGS));
    expect_all_zero();
    $display("clear with pending write: ready low %0d cycles", lowc);

    wb_valid = 1'b1; wb_rd = AW'(6); wb_alu_data = val(6);
    tick();
    idle_in();
    tick();
    push_exp(K_DBG, 6, 64'(val(6)));
    drain_sb();
    clr_req = 1'b1;
    tick();
    idle_in();
    run_clear(1'b0, 0, lowc, done);
    compare("clear_idle_timeout", 0, 0, 64'(done), 64'd1);
    compare("clear_idle_cycles", 0, 0, 64'(lowc), 64'(NREGS - 1));
    push_exp(K_RS, 6, 64'd0);
    push_exp(K_DBG, 6, 64'd0);
    drain_sb();
    $display("clear without pending write: ready low %0d cycles", lowc);

    // Reset in the middle of a clear sweep.
    wb_valid = 1'b1; wb_rd = AW'(NREGS - 7); wb_alu_data = val(NREGS - 7);
    tick();
    wb_rd = AW'(3); wb_alu_data = val(3);
    tick();
    idle_in();
    iss_valid = 1'b1; iss_rd = AW'(NREGS - 2);
    tick();
    idle_in();
    clr_req = 1'b1;
    tick();
    idle_in();
    run_clear(1'b0, 10, lowc, done);
    compare("clear_idx10_reached", 0, 0, 64'(done), 64'd1);
    push_exp(K_RDY, 0, 64'd0);
    push_exp(K_DBG, NREGS - 7, 64'(val(NREGS - 7)));
    push_exp(K_DBG, 3, 64'd0);
    drain_sb();
    rst_n = 1'b0;
    #1;
    expect_all_zero();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push_exp(K_RDY, 0, 64'd1);
    push_exp(K_DBG, NREGS - 7, 64'd0);
    drain_sb();
    wb_valid = 1'b1; wb_rd = AW'(12); wb_sel = 1'b1; wb_mem_data = val(12);
    tick();
    idle_in();
    push_exp(K_RS, 12, 64'(val(12)));
    push_exp(K_DBG, 12, 64'd0);
    drain_sb();
    tick();
    push_exp(K_DBG, 12, 64'(val(12)));
    drain_sb();
    $display("reset during clear: state zeroed, write-back resumes");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
